face_scan_sequencer: RTL
========================

# face_scan_sequencer

Scan-order controller for a face-detection core's Haar-window datapath. From the tile size, it generates every window position and size the detector evaluates, across six scale stages. Each window goes out over a valid/ready handshake, so the detector (integral-image lookups, eye/cheek/nose/mouth tests) can stall freely. One instance sits beside each detection core and starts when the tile image is loaded.

## Interface
- No parameters; geometry is derived at run time from `size`.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `abort` in 1: terminate the sweep; honoured in any non-IDLE state.
- `size` in 32: tile size; latched on accepted `start`. Behaviour is defined for `size` ≤ 65535.
- `win_ready` in 1: detector accepts the current window.
- `win_valid` out 1: window fields are valid.
- `win_x`, `win_y` out 16 each: top-left column and row of the window within the core tile.
- `filt_w`, `filt_h`, `eye_sz` out 16 each: window width, stripe height, eye-segment width.
- `stage` out 3: current scale stage, 1–6 (0 when idle).
- `win_last` out 1: marks the final window of the sweep.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the sweep completes normally.
- `win_count` out 32: number of accepted windows in the current/last sweep.

## Operation
- Latched geometry:
  - U = size/8 (integer division).
  - S = 3U (tile side).
  - X_MAX = S−1−W; Y_MAX = S−1−4H.
- Stage widths (integer arithmetic, evaluated left to right):
  - W1 = 2U/3
  - W2 = W1·3/2
  - W3 = W2·3/2
  - W4 = W3·4/3
  - W5 = W4·5/4
  - W6 = W5·6/5 − 1
- For every stage: H = W/6, E = W/5.
- A stage is skipped if H == 0, or W > S−1, or 4H > S−1.
- Widths cascade from the unskipped formula even when an earlier stage is skipped.
- FSM states: IDLE, CALC, EMIT, DONE.
  - IDLE: outputs cleared. On `start`: latch U and S, clear `win_count`, set stage 1, go to CALC.
  - CALC (exactly 1 cycle per stage): compute W, H, E, X_MAX, Y_MAX and the skip condition.
    - If the stage is not skipped: x=y=0, go to EMIT.
    - If skipped and stage < 6: stage++ and stay in CALC.
    - If skipped and stage == 6: go to DONE.
  - EMIT: `win_valid`=1 with the current fields. On `win_valid && win_ready`:
    - `win_count`++.
    - If x < X_MAX: x++.
    - Else if y < Y_MAX: x=0, y++.
    - Else if stage < 6: stage++, go to CALC.
    - Else: go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE. `win_count` holds its value until the next `start`.
- `win_last` = EMIT && x==X_MAX && y==Y_MAX && no later stage will emit. The lookahead skip check is computed combinationally from the next W.
- `abort`: from CALC, EMIT or DONE, go to IDLE on the next edge. `done` is not pulsed.
- `abort` with a handshake in the same cycle: the transfer counts; then IDLE.
- `start` while busy is ignored. `start` and `abort` together in IDLE: start wins.
- `reset` in any state: IDLE, all outputs to reset values, on the same edge.

## Timing
- Reset values: `win_valid` 0, `win_last` 0, `busy` 0, `done` 0, `stage` 0, `win_x`/`win_y`/`filt_w`/`filt_h`/`eye_sz` 0, `win_count` 0.
- `start` sampled at edge N leads to CALC from edge N+1. If stage 1 is not skipped, `win_valid` is high after edge N+2.
- Each skipped stage adds one CALC cycle.
- Each stage transition costs one dead cycle (CALC); `win_valid` is 0 during CALC.
- With `win_ready` tied high, throughput is one window per cycle within a stage.
- Handshake rules:
  - While `win_valid && !win_ready`, all window fields and `win_last` stay stable.
  - `win_valid` never drops without a transfer, except on `abort` or `reset`.
- `done` is high in the cycle after the final transfer, or after the final CALC if all stages are skipped.
- `busy` falls together with the `done` pulse ending (IDLE entry).

## Test plan
- size=96 (U=12, S=36), `win_ready`=1 → stage W/H/E values 8/1/1, 12/2/2, 18/3/3, 24/4/4, 30/5/6, 35/5/7. Per-stage counts 896, 672, 432, 240, 96, 16. `win_count`=2352; `win_last` is high only at stage 6, x=0, y=15; one `done` pulse.
- size=48 → stage 1 skipped (H=0). Counts 168, 126, 60, 30, 10; `win_count`=394. First window is stage 2 at edge N+3.
- size=16 → all stages skipped. No `win_valid`; `done` pulses after 6 CALC cycles; `win_count`=0.
- size=96 with random `win_ready` backpressure → fields stable across stalls; the sequence is identical to the no-stall run; `win_count`=2352.
- Abort mid-stage-3 in the same cycle as a handshake → that window is counted, IDLE next edge, no `done`. A following `start` re-sweeps from stage 1 and clears `win_count`.
- `reset` asserted during EMIT, and `start` pulsed while busy → all outputs return to reset values on the same edge; the start pulse while busy has no effect.

Source files
------------

// File: rtl/face_scan_sequencer.sv
// face_scan_sequencer
//
// Scan-order controller for a Haar-window face detector. From the tile size
// it derives six scale stages and walks every window position of each stage,
// handing one window at a time to the detector over a valid/ready handshake.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   start      : begin a sweep (sampled only while idle)
//   abort      : end the current sweep immediately (no done pulse)
//   size       : tile size, latched on an accepted start
//   win_ready  : detector accepts the presented window
//   win_valid  : window fields below are valid
//   win_x/y    : top-left column/row of the window
//   filt_w     : window width
//   filt_h     : stripe height
//   eye_sz     : eye-segment width
//   stage      : scale stage 1..6, 0 when idle
//   win_last   : presented window is the final one of the sweep
//   busy       : sweep in progress
//   done       : one-cycle pulse on normal completion
//   win_count  : windows accepted in the current/last sweep

module face_scan_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] size,
    input  logic        win_ready,
    output logic        win_valid,
    output logic [15:0] win_x,
    output logic [15:0] win_y,
    output logic [15:0] filt_w,
    output logic [15:0] filt_h,
    output logic [15:0] eye_sz,
    output logic [2:0]  stage,
    output logic        win_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] win_count
);

    typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

    state_t state_q, state_d;
    logic [2:0]  stage_q, stage_d;
    logic [31:0] count_q, count_d;

    logic signed [31:0] u_q, u_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [15:0] w_q, h_q, e_q, xmax_q, ymax_q;
    logic        ld_fields;

    // Geometry derived from the latched unit size
    logic signed [31:0] smax_c;
    logic signed [31:0] w1, w2, w3, w4, w5, w6;
    logic [6:1]         skip_c;

    // Fields of the stage currently selected by stage_q
    logic signed [31:0] w_sel, h_sel;
    logic [15:0]        e_sel, xmax_sel, ymax_sel;
    logic               skip_sel;
    logic               later_emit;

    // Signed arithmetic keeps W6 = W5*6/5 - 1 at -1 for tiny tiles, where
    // the truncating divide then yields H = 0 and the stage is skipped.
    function automatic logic stage_skipped(input logic signed [31:0] w,
                                           input logic signed [31:0] smax);
        logic signed [31:0] h;
        h = w / 32'sd6;
        return (h == 32'sd0) || (w > smax) || ((32'sd4 * h) > smax);
    endfunction

    assign smax_c = (32'sd3 * u_q) - 32'sd1;

    // Widths cascade from the unskipped formula regardless of skips
    assign w1 = (32'sd2 * u_q) / 32'sd3;
    assign w2 = (w1 * 32'sd3) / 32'sd2;
    assign w3 = (w2 * 32'sd3) / 32'sd2;
    assign w4 = (w3 * 32'sd4) / 32'sd3;
    assign w5 = (w4 * 32'sd5) / 32'sd4;
    assign w6 = ((w5 * 32'sd6) / 32'sd5) - 32'sd1;

    assign skip_c = {stage_skipped(w6, smax_c), stage_skipped(w5, smax_c),
                     stage_skipped(w4, smax_c), stage_skipped(w3, smax_c),
                     stage_skipped(w2, smax_c), stage_skipped(w1, smax_c)};

    // later_emit: some stage after the current one still has windows; this
    // is what lets win_last mark the true final window of the sweep.
    always_comb begin
        w_sel      = '0;
        skip_sel   = 1'b1;
        later_emit = 1'b0;
        case (stage_q)
            3'd1: begin
                w_sel      = w1;
                skip_sel   = skip_c[1];
                later_emit = |(~skip_c[6:2]);
            end
            3'd2: begin
                w_sel      = w2;
                skip_sel   = skip_c[2];
                later_emit = |(~skip_c[6:3]);
            end
            3'd3: begin
                w_sel      = w3;
                skip_sel   = skip_c[3];
                later_emit = |(~skip_c[6:4]);
            end
            3'd4: begin
                w_sel      = w4;
                skip_sel   = skip_c[4];
                later_emit = |(~skip_c[6:5]);
            end
            3'd5: begin
                w_sel      = w5;
                skip_sel   = skip_c[5];
                later_emit = ~skip_c[6];
            end
            3'd6: begin
                w_sel      = w6;
                skip_sel   = skip_c[6];
                later_emit = 1'b0;
            end
            default: begin
                w_sel      = '0;
                skip_sel   = 1'b1;
                later_emit = 1'b0;
            end
        endcase
    end

    assign h_sel    = w_sel / 32'sd6;
    assign e_sel    = 16'(w_sel / 32'sd5);
    assign xmax_sel = 16'(smax_c - w_sel);
    assign ymax_sel = 16'(smax_c - (32'sd4 * h_sel));

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        count_d   = count_q;
        u_d       = u_q;
        x_d       = x_q;
        y_d       = y_q;
        ld_fields = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    u_d     = $signed(size >> 3);
                    count_d = '0;
                    stage_d = 3'd1;
                    state_d = CALC;
                end
            end

            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!skip_sel) begin
                    x_d       = '0;
                    y_d       = '0;
                    ld_fields = 1'b1;
                    state_d   = EMIT;
                end else if (stage_q < 3'd6) begin
                    stage_d = stage_q + 3'd1;
                end else begin
                    state_d = DONE;
                end
            end

            EMIT: begin
                // A transfer in the abort cycle still counts
                if (win_ready) begin
                    count_d = count_q + 32'd1;
                    if (x_q < xmax_q) begin
                        x_d = x_q + 16'd1;
                    end else if (y_q < ymax_q) begin
                        x_d = '0;
                        y_d = y_q + 16'd1;
                    end else if (stage_q < 3'd6) begin
                        stage_d = stage_q + 3'd1;
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    // Data registers; their outputs are forced to zero while idle
    always_ff @(posedge clk) begin
        u_q <= u_d;
        x_q <= x_d;
        y_q <= y_d;
        if (ld_fields) begin
            w_q    <= w_sel[15:0];
            h_q    <= h_sel[15:0];
            e_q    <= e_sel;
            xmax_q <= xmax_sel;
            ymax_q <= ymax_sel;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign win_valid = (state_q == EMIT);
    assign win_last  = win_valid && (x_q == xmax_q) && (y_q == ymax_q) && !later_emit;
    assign stage     = busy ? stage_q : 3'd0;
    assign win_x     = busy ? x_q : 16'd0;
    assign win_y     = busy ? y_q : 16'd0;
    assign filt_w    = busy ? w_q : 16'd0;
    assign filt_h    = busy ? h_q : 16'd0;
    assign eye_sz    = busy ? e_q : 16'd0;
    assign win_count = count_q;

endmodule
